// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit byte buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

  // Clocks per bit, rounded down.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte_buffer_if.sv
// Byte-strobe input and UART/status outputs of the transmit byte buffer.
interface uart_tx_byte_buffer_if;
  import uart_pkg::*;

  logic                      i_en;
  logic [UART_DATA_BITS-1:0] i_data;
  logic                      o_full;
  logic                      o_busy;
  logic                      o_overflow;
  logic                      uart_tx;

  modport master (
    output i_en,
    output i_data,
    input  o_full,
    input  o_busy,
    input  o_overflow,
    input  uart_tx
  );

  modport slave (
    input  i_en,
    input  i_data,
    output o_full,
    output o_busy,
    output o_overflow,
    output uart_tx
  );

endinterface

// File: rtl/uart_tx_byte_buffer_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output; a push while full is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // When full, the slot being popped is the one written, so the old word is
  // read out on the same edge the new one lands.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_byte_buffer.sv
// Buffers strobed bytes and sends each as an 8N1 frame, LSB first; queued
// frames follow each other with no idle gap.
module uart_tx_byte_buffer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_byte_buffer_if.slave bus
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_q,    state_d;
  logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]          bit_idx_q,  bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
  logic                      tx_q,       tx_d;
  logic                      overflow_q, overflow_d;

  logic                      baud_tick;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.i_en),
    .din   (bus.i_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_tick = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (baud_tick) begin
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Line level follows the next state so uart_tx comes straight from a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign overflow_d = bus.i_en && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.uart_tx    = tx_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_full     = fifo_full;
  assign bus.o_busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_byte_buffer.sv
// Scoreboard bench: expected bytes are queued at the strobe, a line monitor
// decodes frames, and each scenario task compares the two plus timing/status.
module tb_uart_tx_byte_buffer;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned BIT_CLKS   = 10;
  localparam int unsigned FRAME_CLKS = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_byte_buffer_if bus();

  uart_tx_byte_buffer #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int unsigned rx_start_q[$];
  int          framing_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: one sample per clock, every bit must hold for BIT_CLKS.
  int unsigned mon_clk = 0;
  logic [9:0]  mon_bits;
  always @(negedge clk) begin
    if (rst) begin
      mon_clk = 0;
    end else if (mon_clk == 0) begin
      if (bus.uart_tx === 1'b0) begin
        mon_bits[0] = 1'b0;
        mon_clk     = 1;
        rx_start_q.push_back(cyc);
      end
    end else begin
      if ((mon_clk % BIT_CLKS) == 0) mon_bits[mon_clk / BIT_CLKS] = bus.uart_tx;
      else if (bus.uart_tx !== mon_bits[mon_clk / BIT_CLKS]) framing_err++;
      mon_clk++;
      if (mon_clk == FRAME_CLKS) begin
        if (mon_bits[9] !== 1'b1) framing_err++;
        rx_q.push_back(mon_bits[8:1]);
        mon_clk = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] d);
    bus.i_en   = 1'b1;
    bus.i_data = d;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < 300 && bus.o_busy !== 1'b0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
    framing_err = 0;
  endtask

  task automatic test_reset();
    bus.i_en   = 1'b0;
    bus.i_data = 8'h00;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow} !== 4'b1000)
      begin failures++; $display("FAIL reset_outputs: got %b expected 1000",
        {bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow} !== 4'b1000)
      begin failures++; $display("FAIL post_reset_outputs: got %b expected 1000",
        {bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow}); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 1000; i++) begin
      checks++;
      if ({bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow} !== 4'b1000)
        begin failures++; $display("FAIL idle_cycle_%0d: got %b expected 1000", i,
          {bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow}); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    logic [7:0] got;
    settle();
    frame = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(8'hA5);
    drive(8'hA5);
    bus.i_en = 1'b0;
    checks++;
    if (bus.uart_tx !== 1'b1 || bus.o_busy !== 1'b1)
      begin failures++; $display("FAIL single_after_strobe: got tx=%b busy=%b expected tx=1 busy=1",
        bus.uart_tx, bus.o_busy); end
    @(negedge clk);
    for (int j = 0; j < 100; j++) begin
      checks++;
      if (bus.uart_tx !== frame[j / 10] || bus.o_busy !== 1'b1)
        begin failures++; $display("FAIL single_frame_clk_%0d: got tx=%b busy=%b expected tx=%b busy=1",
          j, bus.uart_tx, bus.o_busy, frame[j / 10]); end
      @(negedge clk);
    end
    checks++;
    if (bus.uart_tx !== 1'b1 || bus.o_busy !== 1'b0)
      begin failures++; $display("FAIL single_end: got tx=%b busy=%b expected tx=1 busy=0",
        bus.uart_tx, bus.o_busy); end
    wait_rx(1, 20);
    checks++;
    if (rx_q.size() != 1) begin
      failures++; $display("FAIL single_rx_count: got %0d expected 1", rx_q.size());
    end else begin
      got = rx_q.pop_front();
      checks++;
      if (got !== exp_q[0]) begin failures++;
        $display("FAIL single_rx_byte: got %h expected %h", got, exp_q[0]); end
    end
    checks++;
    if (framing_err != 0) begin failures++;
      $display("FAIL single_framing: got %0d errors expected 0", framing_err); end
  endtask

  task automatic test_burst();
    int unsigned c0;
    logic        bad_flag;
    logic [7:0]  got;
    logic [7:0]  want;
    settle();
    bad_flag = 1'b0;
    c0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      drive(8'(i));
      if (bus.o_overflow !== 1'b0 || bus.o_full !== 1'b0) bad_flag = 1'b1;
    end
    bus.i_en = 1'b0;
    for (int t = 0; t < 850 && rx_q.size() < 8; t++) begin
      if (bus.o_overflow !== 1'b0 || bus.o_full !== 1'b0) bad_flag = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad_flag !== 1'b0) begin failures++;
      $display("FAIL burst_status: got overflow/full seen=%b expected 0", bad_flag); end
    checks++;
    if (rx_q.size() != 8) begin
      failures++; $display("FAIL burst_rx_count: got %0d expected 8", rx_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        got  = rx_q.pop_front();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin failures++;
          $display("FAIL burst_rx_byte_%0d: got %h expected %h", k, got, want); end
      end
      checks++;
      if (rx_start_q[0] != c0 + 2) begin failures++;
        $display("FAIL burst_first_latency: got start cycle %0d expected %0d", rx_start_q[0], c0 + 2); end
      for (int k = 1; k < 8; k++) begin
        checks++;
        if (rx_start_q[k] - rx_start_q[k-1] != FRAME_CLKS) begin failures++;
          $display("FAIL burst_gap_%0d: got %0d expected %0d", k,
            rx_start_q[k] - rx_start_q[k-1], FRAME_CLKS); end
      end
    end
    checks++;
    if (framing_err != 0) begin failures++;
      $display("FAIL burst_framing: got %0d errors expected 0", framing_err); end
  endtask

  task automatic test_overflow();
    logic       seen;
    logic [1:0] st;
    logic [1:0] want_st;
    logic [7:0] got;
    logic [7:0] want;
    settle();
    exp_q.push_back(8'h0F);
    drive(8'h0F);
    bus.i_en = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (bus.uart_tx === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin failures++;
      $display("FAIL ovf_start_seen: got %b expected 1", seen); end
    for (int k = 0; k < 10; k++) begin
      if (k < 8) exp_q.push_back(8'(8'h10 + k));
      drive(8'(8'h10 + k));
      st      = {bus.o_full, bus.o_overflow};
      want_st = {(k >= 7) ? 1'b1 : 1'b0, (k >= 8) ? 1'b1 : 1'b0};
      checks++;
      if (st !== want_st) begin failures++;
        $display("FAIL ovf_strobe_%0d: got full,ovf=%b expected %b", k, st, want_st); end
    end
    bus.i_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_full !== 1'b1) begin failures++;
      $display("FAIL ovf_pulse_end: got ovf=%b full=%b expected ovf=0 full=1",
        bus.o_overflow, bus.o_full); end
    wait_rx(9, 1100);
    checks++;
    if (rx_q.size() != 9) begin
      failures++; $display("FAIL ovf_rx_count: got %0d expected 9", rx_q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        got  = rx_q.pop_front();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin failures++;
          $display("FAIL ovf_rx_byte_%0d: got %h expected %h", k, got, want); end
      end
    end
    checks++;
    if (framing_err != 0) begin failures++;
      $display("FAIL ovf_framing: got %0d errors expected 0", framing_err); end
  endtask

  task automatic test_full_with_pop();
    logic       seen;
    logic [7:0] got;
    logic [7:0] want;
    settle();
    exp_q.push_back(8'h60);
    drive(8'h60);
    bus.i_en = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (bus.uart_tx === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin failures++;
      $display("FAIL fullpop_start_seen: got %b expected 1", seen); end
    // Fill during the first frame, then strobe on the stop bit's last clock.
    for (int k = 0; k < 99; k++) begin
      if (k < 8) begin
        exp_q.push_back(8'(8'h70 + k));
        bus.i_en   = 1'b1;
        bus.i_data = 8'(8'h70 + k);
      end else begin
        bus.i_en = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (bus.o_full !== 1'b1 || bus.uart_tx !== 1'b1) begin failures++;
      $display("FAIL fullpop_before: got full=%b tx=%b expected full=1 tx=1", bus.o_full, bus.uart_tx); end
    exp_q.push_back(8'h7F);
    drive(8'h7F);
    bus.i_en = 1'b0;
    checks++;
    if ({bus.o_full, bus.o_overflow, bus.uart_tx} !== 3'b100) begin failures++;
      $display("FAIL fullpop_edge: got full,ovf,tx=%b expected 100",
        {bus.o_full, bus.o_overflow, bus.uart_tx}); end
    wait_rx(10, 1000);
    checks++;
    if (rx_q.size() != 10) begin
      failures++; $display("FAIL fullpop_rx_count: got %0d expected 10", rx_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        got  = rx_q.pop_front();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin failures++;
          $display("FAIL fullpop_rx_byte_%0d: got %h expected %h", k, got, want); end
        if (k > 0) begin
          checks++;
          if (rx_start_q[k] - rx_start_q[k-1] != FRAME_CLKS) begin failures++;
            $display("FAIL fullpop_gap_%0d: got %0d expected %0d", k,
              rx_start_q[k] - rx_start_q[k-1], FRAME_CLKS); end
        end
      end
    end
    checks++;
    if (framing_err != 0) begin failures++;
      $display("FAIL fullpop_framing: got %0d errors expected 0", framing_err); end
  endtask

  task automatic test_reset_mid_frame();
    logic       seen;
    logic       idle_bad;
    logic [7:0] got;
    settle();
    drive(8'h3C);
    bus.i_en = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (bus.uart_tx === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin failures++;
      $display("FAIL rstmid_start_seen: got %b expected 1", seen); end
    drive(8'hC1);
    drive(8'hC2);
    drive(8'hC3);
    bus.i_en = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow} !== 4'b1000) begin failures++;
      $display("FAIL rstmid_outputs: got tx,busy,full,ovf=%b expected 1000",
        {bus.uart_tx, bus.o_busy, bus.o_full, bus.o_overflow}); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
    framing_err = 0;
    idle_bad = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.uart_tx !== 1'b1 || bus.o_busy !== 1'b0) idle_bad = 1'b1;
    end
    checks++;
    if (idle_bad !== 1'b0) begin failures++;
      $display("FAIL rstmid_discard: got activity=%b expected 0", idle_bad); end
    exp_q.push_back(8'h55);
    drive(8'h55);
    bus.i_en = 1'b0;
    for (int t = 0; t < 200; t++) @(negedge clk);
    checks++;
    if (rx_q.size() != 1) begin
      failures++; $display("FAIL rstmid_rx_count: got %0d expected 1", rx_q.size());
    end else begin
      got = rx_q.pop_front();
      checks++;
      if (got !== exp_q[0]) begin failures++;
        $display("FAIL rstmid_rx_byte: got %h expected %h", got, exp_q[0]); end
    end
    checks++;
    if (framing_err != 0) begin failures++;
      $display("FAIL rstmid_framing: got %0d errors expected 0", framing_err); end
  endtask

  initial begin
    bus.i_en   = 1'b0;
    bus.i_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_idle();
    test_single_byte();
    test_burst();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_byte_buffer.md
# uart_tx_byte_buffer

Downstream consumer of the 64-bit-to-8-bit serializer on the UART transmit path. Accepts bytes arriving as single-cycle strobes, including back-to-back bursts of 8, buffers them in a small FIFO and sends each one as an 8N1 UART frame, LSB first. Sits between the serializer and the board TX pin.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in baud
- FIFO_DEPTH, 16, byte buffer depth; power of 2, minimum 8
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- i_en  input  1  byte strobe; one byte per high cycle, no backpressure
- i_data  input  8  byte qualified by i_en
- o_full  output  1  FIFO holds FIFO_DEPTH bytes
- o_busy  output  1  high while a frame is on the line or the FIFO is non-empty
- o_overflow  output  1  one-cycle pulse when a strobed byte is dropped
- uart_tx  output  1  serial line, idle high

## Operation
- BAUD_DIV = CLK_FREQ / BAUD_RATE, integer, rounded down (434 at defaults). Every bit lasts exactly BAUD_DIV clocks.
- Write rule: a byte is accepted when i_en=1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
  - Otherwise the byte is dropped, o_overflow=1 for the next cycle, and FIFO contents are unchanged.
- count is width $clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO is non-empty, pop into the shift register and go to START.
  - START: uart_tx=0 for BAUD_DIV clocks, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0] for BAUD_DIV clocks, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV clocks. On its last clock, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- The baud counter restarts at 0 on every state entry and on every bit.
- o_busy = (state != IDLE) || (count != 0).
- o_full = (count == FIFO_DEPTH).
- Reset values: uart_tx=1, o_full=0, o_busy=0, o_overflow=0, state=IDLE, count=0, pointers=0.
- Reset mid-frame aborts the frame: uart_tx is high from the edge after rst is sampled, and all buffered bytes are discarded.

## Timing
- i_en is sampled at edge N. The byte is visible in the FIFO after edge N.
- From IDLE with an empty FIFO: pop at edge N+1, START begins (uart_tx falls) after edge N+1. First-byte latency is 2 cycles.
- Frame length is 10×BAUD_DIV clocks.
- Queued frames are contiguous: the next start bit begins on the clock right after the last stop-bit clock.
- A burst of 8 consecutive i_en strobes into an empty FIFO never overflows at depth ≥ 8. The first byte is popped 1 cycle after its write.
- o_overflow is registered, 1 cycle after the dropping strobe.
- o_full and o_busy are registered and reflect state after the current edge.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP);
  - a baud_div(CLK_FREQ, BAUD_RATE) constant function;
  - the UART_DATA_BITS=8 constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides:
  - push/pop/dout/count/full/empty, with first-word-fall-through dout;
  - the same-cycle push-on-full-with-pop rule.
- The top level holds the FSM, baud counter, shift register and overflow flag.

## Test plan
All scenarios use CLK_FREQ=1000, BAUD_RATE=100, so BAUD_DIV=10.
- Single byte 0xA5 strobed from idle:
  - uart_tx low 2 cycles after the strobe, for 10 clocks;
  - then bits 1,0,1,0,0,1,0,1 at 10 clocks each;
  - then high 10 clocks. o_busy drops after 100 frame clocks.
- Burst of 8 strobes, bytes 0x01..0x08, in consecutive cycles:
  - 8 contiguous frames (800 clocks), decoded in order;
  - o_overflow never asserted, o_full never asserted.
- FIFO_DEPTH=8 and 10 consecutive strobes 0x10..0x19 while a frame is already active:
  - bytes 0x10..0x17 are sent;
  - 0x18 and 0x19 are dropped, each followed by a 1-cycle o_overflow pulse;
  - o_full high after the 8th write.
- FIFO full and i_en coincides with the STOP-to-START pop:
  - byte accepted, count stays 8, no overflow.
- rst asserted mid-DATA of 0x3C with 3 bytes queued:
  - uart_tx=1, o_busy=0, count=0 after the edge;
  - after rst is released, a new 0x55 is transmitted correctly.
- No i_en for 1000 clocks after reset:
  - uart_tx constantly 1;
  - all status outputs 0.
